// File: rtl/cond_split.sv
// Conditional split: pairs data tokens with condition tokens in arrival order and
// routes each data token to the true or false branch, with per-input pairing FIFOs.

module cond_split_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [N-1:0] i_data,
    output logic [N-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    // Storage array; the write port only, contents need no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy is unchanged on push+pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= AW'(0);
            r_rptr <= AW'(0);
            r_cnt  <= (AW+1)'(0);
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_cnt == (AW+1)'(0));
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
endmodule

module cond_split #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_r_in1,
    input  logic [N-1:0] i_d_in1,
    input  logic         i_r_in2,
    input  logic [N-1:0] i_d_in2,
    output logic         o_r_out1,
    output logic [N-1:0] o_d_out1,
    output logic         o_r_out2,
    output logic [N-1:0] o_d_out2,
    output logic         o_ovf
);
    logic         w_acc1;
    logic         w_acc2;
    logic [N-1:0] w_head1;
    logic [N-1:0] w_head2;
    logic         w_empty1;
    logic         w_empty2;
    logic         w_full1;
    logic         w_full2;
    logic         w_fire;
    logic         w_pop1;
    logic         w_pop2;
    logic         w_byp1;
    logic         w_byp2;
    logic [N-1:0] w_data;
    logic [N-1:0] w_cond;
    logic         w_push1;
    logic         w_push2;
    logic         w_drop;
    logic         w_true;

    assign w_acc1 = i_en & i_r_in1;
    assign w_acc2 = i_en & i_r_in2;

    cond_split_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_data (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push1),
        .i_pop   (w_pop1),
        .i_data  (i_d_in1),
        .o_head  (w_head1),
        .o_empty (w_empty1),
        .o_full  (w_full1)
    );

    cond_split_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_cond (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push2),
        .i_pop   (w_pop2),
        .i_data  (i_d_in2),
        .o_head  (w_head2),
        .o_empty (w_empty2),
        .o_full  (w_full2)
    );

    // Pair selection: buffered heads first, otherwise bypass the strobing input.
    always_comb begin
        w_fire = 1'b0;
        w_pop1 = 1'b0;
        w_pop2 = 1'b0;
        w_byp1 = 1'b0;
        w_byp2 = 1'b0;
        w_data = w_head1;
        w_cond = w_head2;
        if (!w_empty1 && !w_empty2) begin
            w_fire = i_en;
            w_pop1 = i_en;
            w_pop2 = i_en;
        end else if (!w_empty1) begin
            w_fire = w_acc2;
            w_pop1 = w_acc2;
            w_byp2 = w_acc2;
            w_cond = i_d_in2;
        end else if (!w_empty2) begin
            w_fire = w_acc1;
            w_pop2 = w_acc1;
            w_byp1 = w_acc1;
            w_data = i_d_in1;
        end else begin
            w_fire = w_acc1 & w_acc2;
            w_byp1 = w_acc1 & w_acc2;
            w_byp2 = w_acc1 & w_acc2;
            w_data = i_d_in1;
            w_cond = i_d_in2;
        end
    end

    // A token not consumed by bypass is buffered unless its FIFO is full with no pop.
    always_comb begin
        w_push1 = 1'b0;
        w_push2 = 1'b0;
        w_drop  = 1'b0;
        if (w_acc1 && !w_byp1) begin
            w_push1 = !w_full1 || w_pop1;
            w_drop  = w_full1 && !w_pop1;
        end else begin
            w_push1 = 1'b0;
        end
        if (w_acc2 && !w_byp2) begin
            w_push2 = !w_full2 || w_pop2;
            w_drop  = w_drop || (w_full2 && !w_pop2);
        end else begin
            w_push2 = 1'b0;
        end
    end

    assign w_true = (w_cond != {N{1'b0}});

    // Registered branch outputs; the unselected branch data holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r_out1 <= 1'b0;
            o_r_out2 <= 1'b0;
            o_d_out1 <= {N{1'b0}};
            o_d_out2 <= {N{1'b0}};
        end else begin
            o_r_out1 <= w_fire && w_true;
            o_r_out2 <= w_fire && !w_true;
            if (w_fire && w_true) begin
                o_d_out1 <= w_data;
            end
            if (w_fire && !w_true) begin
                o_d_out2 <= w_data;
            end
        end
    end

    // Sticky overflow, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
        end else if (w_drop) begin
            o_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cond_split.sv
// Directed self-checking bench for cond_split (N=16, DEPTH=4).

module tb_cond_split;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        r_in1;
    logic [15:0] d_in1;
    logic        r_in2;
    logic [15:0] d_in2;
    logic        r_out1;
    logic [15:0] d_out1;
    logic        r_out2;
    logic [15:0] d_out2;
    logic        ovf;

    int n_chk;
    int n_fail;

    cond_split #(.N(16), .DEPTH(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_r_in1  (r_in1),
        .i_d_in1  (d_in1),
        .i_r_in2  (r_in2),
        .i_d_in2  (d_in2),
        .o_r_out1 (r_out1),
        .o_d_out1 (d_out1),
        .o_r_out2 (r_out2),
        .o_d_out2 (d_out2),
        .o_ovf    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic cyc(input logic e, input logic a, input logic [15:0] da,
                       input logic b, input logic [15:0] db);
        en = e; r_in1 = a; d_in1 = da; r_in2 = b; d_in2 = db;
        @(negedge clk);
        en = 1'b1; r_in1 = 1'b0; r_in2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; r_in1 = 1'b0; r_in2 = 1'b0; d_in1 = 16'h0; d_in2 = 16'h0;
        @(negedge clk);
        n_chk++;
        if ({r_out1, r_out2, d_out1, d_out2, ovf} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_state: got r1=%b r2=%b d1=%h d2=%h ovf=%b, want all 0", r_out1, r_out2, d_out1, d_out2, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_same_cycle();
        cyc(1'b1, 1'b1, 16'h0042, 1'b1, 16'h0001);
        n_chk++;
        if (r_out1 !== 1'b1 || d_out1 !== 16'h0042 || r_out2 !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle: got r1=%b d1=%h r2=%b, want r1=1 d1=0042 r2=0", r_out1, d_out1, r_out2);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        n_chk++;
        if (r_out1 !== 1'b0 || d_out1 !== 16'h0042) begin
            n_fail++;
            $display("FAIL same_cycle_hold: got r1=%b d1=%h, want r1=0 d1=0042", r_out1, d_out1);
        end
    endtask

    task automatic test_in_order();
        cyc(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h0020, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h0030, 1'b0, 16'h0);
        n_chk++;
        if (r_out1 !== 1'b0 || r_out2 !== 1'b0) begin
            n_fail++;
            $display("FAIL order_no_cond: got r1=%b r2=%b, want 0 0", r_out1, r_out2);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0000);
        n_chk++;
        if (r_out2 !== 1'b1 || d_out2 !== 16'h0010 || r_out1 !== 1'b0) begin
            n_fail++;
            $display("FAIL order_1: got r1=%b r2=%b d2=%h, want r1=0 r2=1 d2=0010", r_out1, r_out2, d_out2);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0005);
        n_chk++;
        if (r_out1 !== 1'b1 || d_out1 !== 16'h0020 || r_out2 !== 1'b0 || d_out2 !== 16'h0010) begin
            n_fail++;
            $display("FAIL order_2: got r1=%b d1=%h r2=%b d2=%h, want 1 0020 0 0010", r_out1, d_out1, r_out2, d_out2);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0000);
        n_chk++;
        if (r_out2 !== 1'b1 || d_out2 !== 16'h0030 || r_out1 !== 1'b0 || d_out1 !== 16'h0020) begin
            n_fail++;
            $display("FAIL order_3: got r1=%b d1=%h r2=%b d2=%h, want 0 0020 1 0030", r_out1, d_out1, r_out2, d_out2);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 16'h0101 + 16'(i), 1'b0, 16'h0);
            if (i == 3) begin
                n_chk++;
                if (ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_at_full: got ovf=%b, want 0", ovf);
                end
            end
        end
        n_chk++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b, want 1", ovf);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0001);
            n_chk++;
            if (r_out1 !== 1'b1 || d_out1 !== (16'h0101 + 16'(i)) || r_out2 !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: got r1=%b d1=%h r2=%b, want 1 %h 0", i, r_out1, d_out1, r_out2, 16'h0101 + 16'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            n_chk++;
            if (r_out1 !== 1'b0 || r_out2 !== 1'b0 || ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_after_drain: got r1=%b r2=%b ovf=%b, want 0 0 1", r_out1, r_out2, ovf);
            end
        end
    endtask

    task automatic test_full_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 16'h0201 + 16'(i), 1'b0, 16'h0);
        end
        cyc(1'b1, 1'b1, 16'h0205, 1'b1, 16'h0000);
        n_chk++;
        if (r_out2 !== 1'b1 || d_out2 !== 16'h0201 || r_out1 !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: got r1=%b r2=%b d2=%h ovf=%b, want 0 1 0201 0", r_out1, r_out2, d_out2, ovf);
        end
        cyc(1'b1, 1'b1, 16'h02ff, 1'b0, 16'h0);
        n_chk++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL full_still_4: got ovf=%b, want 1", ovf);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0003);
            n_chk++;
            if (r_out1 !== 1'b1 || d_out1 !== (16'h0202 + 16'(i))) begin
                n_fail++;
                $display("FAIL full_drain_%0d: got r1=%b d1=%h, want 1 %h", i, r_out1, d_out1, 16'h0202 + 16'(i));
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        cyc(1'b1, 1'b1, 16'h0301, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h0302, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 16'h03aa, 1'b1, 16'h0001);
            n_chk++;
            if (r_out1 !== 1'b0 || r_out2 !== 1'b0 || d_out1 !== 16'h0 || d_out2 !== 16'h0) begin
                n_fail++;
                $display("FAIL en_low_%0d: got r1=%b r2=%b d1=%h d2=%h, want 0 0 0000 0000", i, r_out1, r_out2, d_out1, d_out2);
            end
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0001);
        n_chk++;
        if (r_out1 !== 1'b1 || d_out1 !== 16'h0301) begin
            n_fail++;
            $display("FAIL en_resume_1: got r1=%b d1=%h, want 1 0301", r_out1, d_out1);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0000);
        n_chk++;
        if (r_out2 !== 1'b1 || d_out2 !== 16'h0302) begin
            n_fail++;
            $display("FAIL en_resume_2: got r2=%b d2=%h, want 1 0302", r_out2, d_out2);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0001);
        n_chk++;
        if (r_out1 !== 1'b0 || r_out2 !== 1'b0) begin
            n_fail++;
            $display("FAIL en_nothing_accepted: got r1=%b r2=%b, want 0 0", r_out1, r_out2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 16'h0401 + 16'(i), 1'b0, 16'h0);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0001);
        n_chk++;
        if (r_out1 !== 1'b1 || d_out1 !== 16'h0401 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got r1=%b d1=%h ovf=%b, want 1 0401 1", r_out1, d_out1, ovf);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({r_out1, r_out2, d_out1, d_out2, ovf} !== 35'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got r1=%b r2=%b d1=%h d2=%h ovf=%b, want all 0", r_out1, r_out2, d_out1, d_out2, ovf);
        end
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0001);
        n_chk++;
        if (r_out1 !== 1'b0 || r_out2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_discard_1: got r1=%b r2=%b, want 0 0", r_out1, r_out2);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0001);
        n_chk++;
        if (r_out1 !== 1'b0 || r_out2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_discard_2: got r1=%b r2=%b, want 0 0", r_out1, r_out2);
        end
        cyc(1'b1, 1'b1, 16'h04aa, 1'b0, 16'h0);
        n_chk++;
        if (r_out1 !== 1'b1 || d_out1 !== 16'h04aa) begin
            n_fail++;
            $display("FAIL rstmid_new_data: got r1=%b d1=%h, want 1 04aa", r_out1, d_out1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dv [4];
        logic [15:0] cv [4];
        dv = '{16'h0501, 16'h0502, 16'h0503, 16'h0504};
        cv = '{16'h0001, 16'h0000, 16'h0007, 16'h0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, dv[i], 1'b1, cv[i]);
            n_chk++;
            if (cv[i] != 16'h0) begin
                if (r_out1 !== 1'b1 || r_out2 !== 1'b0 || d_out1 !== dv[i]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got r1=%b r2=%b d1=%h, want 1 0 %h", i, r_out1, r_out2, d_out1, dv[i]);
                end
            end else begin
                if (r_out2 !== 1'b1 || r_out1 !== 1'b0 || d_out2 !== dv[i]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got r1=%b r2=%b d2=%h, want 0 1 %h", i, r_out1, r_out2, d_out2, dv[i]);
                end
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_same_cycle();
        test_in_order();
        test_overflow();
        test_full_bypass();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cond_split.md
COND_SPLIT -- requirements
Module: cond_split

Interface
REQ-001 Parameter N, default 16, meaning data and condition token width in bits.
REQ-002 Parameter DEPTH, default 4, meaning per-input pairing FIFO depth in tokens (power of two, >=2).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  global enable; low freezes all internal state.
REQ-006 R_IN1  input  1  one-cycle ready strobe qualifying D_IN1 (data token).
REQ-007 D_IN1  input  N  data token.
REQ-008 R_IN2  input  1  one-cycle ready strobe qualifying D_IN2 (condition token).
REQ-009 D_IN2  input  N  condition token; nonzero means true.
REQ-010 R_OUT1  output  1  one-cycle strobe: data token routed to true branch.
REQ-011 D_OUT1  output  N  true-branch data, registered.
REQ-012 R_OUT2  output  1  one-cycle strobe: data token routed to false branch.
REQ-013 D_OUT2  output  N  false-branch data, registered.
REQ-014 OVF  output  1  sticky overflow flag: a token was dropped.

Function
REQ-015 Protocol: no backpressure; a token is accepted when R_INx=1 and EN=1 at a clock edge.
REQ-016 Each input SHALL push accepted tokens into its own DEPTH-entry FIFO, in arrival order.
REQ-017 A pair is ready when both FIFOs are non-empty, or when one FIFO is non-empty and the other input strobes in the same cycle (bypass).
REQ-018 On a ready pair with EN=1, the block SHALL pop the heads, using the condition head (or bypassed D_IN2) and the data head (or bypassed D_IN1) together.
REQ-019 If the condition is nonzero, the data SHALL appear on D_OUT1 with R_OUT1=1 for exactly one cycle; otherwise on D_OUT2 with R_OUT2=1.
REQ-020 Latency: a pair whose later token arrives at edge k SHALL produce its output strobe in the cycle following edge k (1-cycle latency).
REQ-021 Throughput: one pair per cycle; R_OUT1 and R_OUT2 are never high in the same cycle.
REQ-022 Tokens SHALL be paired strictly in order: the i-th data token is paired with the i-th condition token.
REQ-023 The non-selected D_OUTx SHALL hold its previous value; D_OUTx SHALL hold after its strobe falls.
REQ-024 Push and pop on the same FIFO in the same cycle SHALL be legal at any occupancy, including full: occupancy is unchanged.
REQ-025 A token arriving at a full FIFO with no same-cycle pop SHALL be dropped, and OVF SHALL set and stay set until reset.
REQ-026 Both inputs strobing with both FIFOs empty SHALL pair directly with no FIFO write.
REQ-027 With EN=0: no push, no pop, R_OUT1=R_OUT2=0, and D_OUTx, FIFO contents and pointers are held; strobes arriving are ignored.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; occupancy is tracked with a log2(DEPTH)+1-bit counter.

Reset
REQ-029 RST=0 SHALL immediately clear R_OUT1, R_OUT2, D_OUT1, D_OUT2, OVF to 0 and empty both FIFOs.
REQ-030 Reset mid-operation SHALL discard all buffered tokens; no strobe SHALL be emitted for them after release.
REQ-031 The first edge with RST=1 SHALL already accept tokens.

Verification
REQ-032 Same-cycle pair D_IN1=0x0042, D_IN2=0x0001 -> next cycle R_OUT1=1, D_OUT1=0x0042, R_OUT2=0.
REQ-033 Data 0x0010, 0x0020, 0x0030 on three cycles, then conditions 0, 5, 0 on three later cycles -> D_OUT2=0x0010, D_OUT1=0x0020, D_OUT2=0x0030, each one cycle after its condition, in that order.
REQ-034 Five data tokens with no conditions (DEPTH=4) -> fifth token dropped, OVF=1; then four conditions of 1 -> exactly four R_OUT1 strobes carrying tokens 1-4.
REQ-035 Full data FIFO plus a condition strobe and a data strobe in the same cycle -> one output strobe, occupancy stays 4, OVF stays 0.
REQ-036 Two tokens buffered, EN=0 for three cycles with strobes applied, then EN=1 -> no outputs and no accepts while EN=0; buffered state resumes intact.
REQ-037 Three data tokens buffered, RST pulsed low mid-cycle -> outputs and OVF are 0 immediately; later conditions produce no output until new data arrives.
